// File: rtl/prince_api_master.sv
// Host-side bus initiator for the PRINCE cipher register wrapper.
// Takes one key/block/mode request, programs the cipher over a simple
// cs/we register bus, waits for completion and returns the 64-bit result.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start
// PRECHECK | read STATUS until ready; the responder drops writes otherwise
// WR_CFG   | write CONFIG with the mode bit
// WR_KEY   | write KEY0..KEY3, one word per cycle
// WR_BLK   | write BLOCK0, BLOCK1
// WR_CTRL  | write CTRL = NEXT
// DELAY    | POLL_DELAY quiet cycles before polling
// POLL     | read STATUS until ready or timeout
// RD0      | read RESULT0 into staging
// RD1      | read RESULT1, update result
// FIN      | done pulse; a new start may be taken here
// ERR      | error pulse; a new start may be taken here
module prince_api_master #(
  parameter int unsigned POLL_DELAY = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          encdec,
  input  logic [127:0]  key,
  input  logic [63:0]   block,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [63:0]   result,
  output logic          cs,
  output logic          we,
  output logic [7:0]    address,
  output logic [31:0]   write_data,
  input  logic [31:0]   read_data
);

  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [3:0]    DLY_LOAD = 4'(POLL_DELAY - 1);

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_CONFIG = 8'h0a;
  localparam logic [7:0] ADDR_RES0   = 8'h30;
  localparam logic [7:0] ADDR_RES1   = 8'h31;

  typedef enum logic [3:0] {
    S_IDLE, S_PRECHECK, S_WR_CFG, S_WR_KEY, S_WR_BLK, S_WR_CTRL,
    S_DELAY, S_POLL, S_RD0, S_RD1, S_FIN, S_ERR
  } state_t;

  state_t           state, state_d;
  logic [1:0]       idx, idx_d;
  logic [TW-1:0]    to_cnt, to_cnt_d;
  logic [3:0]       dly, dly_d;
  logic             accept;

  logic             encdec_q;
  logic [3:0][31:0] key_q;
  logic [1:0][31:0] block_q;
  logic [31:0]      staging;

  logic             cs_d, we_d, busy_d, done_d, error_d;
  logic [7:0]       address_d;
  logic [31:0]      write_data_d;

  // Next-state, counter updates and the bus/status values for the next cycle.
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    to_cnt_d     = to_cnt;
    dly_d        = dly;
    accept       = 1'b0;
    cs_d         = 1'b0;
    we_d         = 1'b0;
    address_d    = address;
    write_data_d = write_data;

    case (state)
      S_IDLE, S_FIN, S_ERR: begin
        state_d = S_IDLE;
        if (start) begin
          state_d  = S_PRECHECK;
          accept   = 1'b1;
          to_cnt_d = '0;
        end
      end
      S_PRECHECK, S_POLL: begin
        if (read_data[0]) begin
          state_d = (state == S_PRECHECK) ? S_WR_CFG : S_RD0;
        end else if (to_cnt >= TO_LAST) begin
          state_d = S_ERR;
        end else if (to_cnt != {TW{1'b1}}) begin
          to_cnt_d = to_cnt + 1'b1;
        end
      end
      S_WR_CFG: begin
        state_d = S_WR_KEY;
        idx_d   = 2'd0;
      end
      S_WR_KEY: begin
        if (idx == 2'd3) begin
          state_d = S_WR_BLK;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx + 2'd1;
        end
      end
      S_WR_BLK: begin
        if (idx == 2'd1) begin
          state_d = S_WR_CTRL;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx + 2'd1;
        end
      end
      S_WR_CTRL: begin
        state_d = S_DELAY;
        dly_d   = DLY_LOAD;
      end
      S_DELAY: begin
        if (dly == 4'd0) begin
          state_d  = S_POLL;
          to_cnt_d = '0;
        end else begin
          dly_d = dly - 4'd1;
        end
      end
      S_RD0:   state_d = S_RD1;
      S_RD1:   state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered, so they follow the state being entered.
    case (state_d)
      S_PRECHECK, S_POLL: begin
        cs_d      = 1'b1;
        address_d = ADDR_STATUS;
      end
      S_WR_CFG: begin
        cs_d         = 1'b1;
        we_d         = 1'b1;
        address_d    = ADDR_CONFIG;
        write_data_d = {31'b0, encdec_q};
      end
      S_WR_KEY: begin
        cs_d         = 1'b1;
        we_d         = 1'b1;
        address_d    = {6'b000100, idx_d};
        write_data_d = key_q[idx_d];
      end
      S_WR_BLK: begin
        cs_d         = 1'b1;
        we_d         = 1'b1;
        address_d    = {7'b0010000, idx_d[0]};
        write_data_d = block_q[idx_d[0]];
      end
      S_WR_CTRL: begin
        cs_d         = 1'b1;
        we_d         = 1'b1;
        address_d    = ADDR_CTRL;
        write_data_d = 32'h1;
      end
      S_RD0: begin
        cs_d      = 1'b1;
        address_d = ADDR_RES0;
      end
      S_RD1: begin
        cs_d      = 1'b1;
        address_d = ADDR_RES1;
      end
      default: ;
    endcase

    busy_d  = !(state_d inside {S_IDLE, S_FIN, S_ERR});
    done_d  = (state_d == S_FIN);
    error_d = (state_d == S_ERR);
  end

  // State, counters, request capture, result assembly and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      to_cnt     <= '0;
      dly        <= '0;
      encdec_q   <= 1'b0;
      key_q      <= '0;
      block_q    <= '0;
      staging    <= '0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cs         <= 1'b0;
      we         <= 1'b0;
      address    <= '0;
      write_data <= '0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      to_cnt     <= to_cnt_d;
      dly        <= dly_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      cs         <= cs_d;
      we         <= we_d;
      address    <= address_d;
      write_data <= write_data_d;
      if (accept) begin
        encdec_q <= encdec;
        key_q    <= key;
        block_q  <= block;
      end
      if (state == S_RD0) staging <= read_data;
      if (state == S_RD1) result  <= {read_data, staging};
    end
  end

endmodule

// File: tb/tb_prince_api_master.sv
// Bench for prince_api_master: a behavioural register responder with a
// reversible stand-in cipher, a bus monitor, and a result scoreboard.
module tb_prince_api_master;

  localparam int PD = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          encdec = 1'b0;
  logic [127:0]  key = '0;
  logic [63:0]   block = '0;
  logic          busy, done, error, cs, we;
  logic [63:0]   result;
  logic [7:0]    address;
  logic [31:0]   write_data, read_data;

  prince_api_master #(.POLL_DELAY(PD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .encdec(encdec), .key(key),
    .block(block), .busy(busy), .done(done), .error(error), .result(result),
    .cs(cs), .we(we), .address(address), .write_data(write_data),
    .read_data(read_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_acc = 0;
  int got_rd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in cipher: encrypt = (b ^ k_lo) + k_hi, decrypt is its inverse.
  function automatic logic [63:0] toy(input logic [127:0] k, input logic [63:0] b, input logic e);
    if (e) toy = (b ^ k[63:0]) + k[127:64];
    else   toy = (b - k[127:64]) ^ k[63:0];
  endfunction

  function automatic logic [39:0] exp_wr(input logic [127:0] k, input logic [63:0] b,
                                         input logic e, input int i);
    case (i)
      0:       exp_wr = {8'h0a, 31'b0, e};
      1:       exp_wr = {8'h10, k[31:0]};
      2:       exp_wr = {8'h11, k[63:32]};
      3:       exp_wr = {8'h12, k[95:64]};
      4:       exp_wr = {8'h13, k[127:96]};
      5:       exp_wr = {8'h20, b[31:0]};
      6:       exp_wr = {8'h21, b[63:32]};
      default: exp_wr = {8'h08, 32'h1};
    endcase
  endfunction

  // Responder: drops writes unless ready; ready can be stuck low or held
  // low for hold_cfg status reads after each NEXT.
  logic        r_cfg = 1'b0;
  logic [31:0] r_key [4];
  logic [31:0] r_blk [2];
  logic [63:0] r_res = '0;
  int          hold = 0;
  bit          stuck_low = 1'b0;
  int          hold_cfg = 0;
  logic        rdy;

  assign rdy = !stuck_low && (hold == 0);

  always @(posedge clk) begin
    if (cs && we && rdy) begin
      case (address)
        8'h0a: r_cfg <= write_data[0];
        8'h10, 8'h11, 8'h12, 8'h13: r_key[address[1:0]] <= write_data;
        8'h20, 8'h21: r_blk[address[0]] <= write_data;
        8'h08: if (write_data[0]) begin
          r_res <= toy({r_key[3], r_key[2], r_key[1], r_key[0]}, {r_blk[1], r_blk[0]}, r_cfg);
          hold  <= hold_cfg;
        end
        default: ;
      endcase
    end
    if (cs && !we && address == 8'h09 && hold != 0) hold <= hold - 1;
  end

  always_comb begin
    read_data = '0;
    if (cs && !we) begin
      case (address)
        8'h09:   read_data = {31'b0, rdy};
        8'h30:   read_data = r_res[31:0];
        8'h31:   read_data = r_res[63:32];
        default: read_data = '0;
      endcase
    end
  end

  // Bus monitor, sampled on the falling edge.
  logic [39:0] wr_q [$];
  logic [63:0] got_q [$];
  logic [63:0] exp_q [$];
  int n_stat = 0, n_done = 0, n_err = 0, n_illegal = 0;
  int ctrl_cyc = 0, first_poll_cyc = 0;
  bit after_ctrl = 1'b0;

  always @(negedge clk) begin
    if (cs && we) wr_q.push_back({address, write_data});
    if (cs && !we && address == 8'h09) begin
      n_stat <= n_stat + 1;
      if (after_ctrl) begin
        first_poll_cyc <= cyc;
        after_ctrl     <= 1'b0;
      end
    end
    if (cs && we && address == 8'h08) begin
      ctrl_cyc   <= cyc;
      after_ctrl <= 1'b1;
    end
    if (cs && !(address inside {8'h08, 8'h09, 8'h0a, 8'h10, 8'h11, 8'h12, 8'h13,
                                8'h20, 8'h21, 8'h30, 8'h31}))
      n_illegal <= n_illegal + 1;
    if (done) begin
      n_done <= n_done + 1;
      got_q.push_back(result);
    end
    if (error) n_err <= n_err + 1;
  end

  task automatic launch(input logic [127:0] k, input logic [63:0] b, input logic e);
    key = k; block = b; encdec = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_end(input int bound, output bit got_done, output bit got_err);
    got_done = 1'b0;
    got_err  = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (done === 1'b1) got_done = 1'b1;
      if (error === 1'b1) got_err = 1'b1;
      if (got_done || got_err) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if ({busy, done, error, cs, we} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctl: got %b expected 00000", {busy, done, error, cs, we});
    end
    n_cmp++; if (result !== 64'h0) begin
      n_bad++; $display("FAIL reset_result: got %h expected 0", result);
    end
    n_cmp++; if (address !== 8'h0 || write_data !== 32'h0) begin
      n_bad++; $display("FAIL reset_bus: got %h/%h expected 0/0", address, write_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_order();
    logic [127:0] k = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    logic [63:0]  b = 64'h01234567_89abcdef;
    int w0 = wr_q.size();
    int d0 = n_done;
    int e0 = n_err;
    bit gd, ge;
    exp_q.push_back(toy(k, b, 1'b1));
    launch(k, b, 1'b1);
    wait_end(40, gd, ge);
    #1;
    n_cmp++; if (gd !== 1'b1 || ge !== 1'b0) begin
      n_bad++; $display("FAIL basic_end: got done=%b err=%b expected 1/0", gd, ge);
    end
    n_cmp++; if (cyc - t_acc !== 11 + PD + 1) begin
      n_bad++; $display("FAIL basic_latency: got %0d expected %0d", cyc - t_acc, 11 + PD + 1);
    end
    n_cmp++; if (busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_busy_at_done: got %b expected 0", busy);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (wr_q.size() - w0 !== 8) begin
      n_bad++; $display("FAIL basic_wr_count: got %0d expected 8", wr_q.size() - w0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++; if (wr_q[w0 + i] !== exp_wr(k, b, 1'b1, i)) begin
          n_bad++; $display("FAIL basic_wr%0d: got %h expected %h", i, wr_q[w0 + i], exp_wr(k, b, 1'b1, i));
        end
      end
    end
    n_cmp++; if (n_done - d0 !== 1 || n_err - e0 !== 0) begin
      n_bad++; $display("FAIL basic_pulses: got done=%0d err=%0d expected 1/0", n_done - d0, n_err - e0);
    end
    n_cmp++; if (got_q.size() <= got_rd) begin
      n_bad++; $display("FAIL basic_result: got none expected %h", exp_q[0]);
      void'(exp_q.pop_front());
    end else begin
      logic [63:0] ex = exp_q.pop_front();
      if (got_q[got_rd] !== ex) begin
        n_bad++; $display("FAIL basic_result: got %h expected %h", got_q[got_rd], ex);
      end
      got_rd++;
    end
  endtask

  task automatic test_roundtrip();
    logic [127:0] k = 128'hdeadbeef_01234567_a5a5a5a5_0badf00d;
    logic [63:0]  c = toy(k, 64'hffffffff_ffffffff, 1'b1);
    bit gd, ge;
    exp_q.push_back(c);
    exp_q.push_back(64'hffffffff_ffffffff);
    launch(k, 64'hffffffff_ffffffff, 1'b1);
    wait_end(40, gd, ge);
    @(negedge clk);
    launch(k, c, 1'b0);
    wait_end(40, gd, ge);
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      logic [63:0] ex = exp_q.pop_front();
      n_cmp++; if (got_q.size() <= got_rd) begin
        n_bad++; $display("FAIL roundtrip%0d: got none expected %h", i, ex);
      end else begin
        if (got_q[got_rd] !== ex) begin
          n_bad++; $display("FAIL roundtrip%0d: got %h expected %h", i, got_q[got_rd], ex);
        end
        got_rd++;
      end
    end
  endtask

  task automatic test_timeout();
    logic [63:0] r_before;
    int s0, w0, d0, e0, g0;
    bit gd, ge;
    stuck_low = 1'b1;
    @(negedge clk);
    #1;
    r_before = result;
    s0 = n_stat; w0 = wr_q.size(); d0 = n_done; e0 = n_err; g0 = got_q.size();
    @(negedge clk);
    launch(128'h1, 64'h2, 1'b1);
    wait_end(30, gd, ge);
    #1;
    n_cmp++; if (ge !== 1'b1 || gd !== 1'b0) begin
      n_bad++; $display("FAIL timeout_end: got done=%b err=%b expected 0/1", gd, ge);
    end
    n_cmp++; if (cyc - t_acc !== TO) begin
      n_bad++; $display("FAIL timeout_latency: got %0d expected %0d", cyc - t_acc, TO);
    end
    n_cmp++; if (busy !== 1'b0) begin
      n_bad++; $display("FAIL timeout_busy: got %b expected 0", busy);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (n_stat - s0 !== TO) begin
      n_bad++; $display("FAIL timeout_reads: got %0d expected %0d", n_stat - s0, TO);
    end
    n_cmp++; if (wr_q.size() - w0 !== 0) begin
      n_bad++; $display("FAIL timeout_writes: got %0d expected 0", wr_q.size() - w0);
    end
    n_cmp++; if (n_err - e0 !== 1 || n_done - d0 !== 0 || got_q.size() !== g0) begin
      n_bad++; $display("FAIL timeout_pulses: got err=%0d done=%0d expected 1/0", n_err - e0, n_done - d0);
    end
    n_cmp++; if (result !== r_before) begin
      n_bad++; $display("FAIL timeout_result_held: got %h expected %h", result, r_before);
    end
    stuck_low = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_poll_latency();
    logic [127:0] k = 128'h11112222_33334444_55556666_77778888;
    logic [63:0]  b = 64'hcafef00d_12345678;
    int s0;
    bit gd, ge;
    hold_cfg = 3;
    s0 = n_stat;
    exp_q.push_back(toy(k, b, 1'b1));
    launch(k, b, 1'b1);
    wait_end(50, gd, ge);
    #1;
    n_cmp++; if (gd !== 1'b1 || cyc - t_acc !== 17) begin
      n_bad++; $display("FAIL poll_latency: got done=%b at T+%0d expected 1 at T+18", gd, cyc - t_acc + 1);
    end
    n_cmp++; if (first_poll_cyc - ctrl_cyc !== PD + 1) begin
      n_bad++; $display("FAIL poll_gap: got %0d expected %0d", first_poll_cyc - ctrl_cyc, PD + 1);
    end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (n_stat - s0 !== 5) begin
      n_bad++; $display("FAIL poll_reads: got %0d expected 5", n_stat - s0);
    end
    begin
      logic [63:0] ex = exp_q.pop_front();
      n_cmp++; if (got_q.size() <= got_rd) begin
        n_bad++; $display("FAIL poll_result: got none expected %h", ex);
      end else begin
        if (got_q[got_rd] !== ex) begin
          n_bad++; $display("FAIL poll_result: got %h expected %h", got_q[got_rd], ex);
        end
        got_rd++;
      end
    end
    hold_cfg = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [127:0] k1 = 128'h00000001_00000002_00000003_00000004;
    logic [63:0]  b1 = 64'h89abcdef_01234567;
    logic [127:0] k2 = 128'hfedcba98_76543210_0f1e2d3c_4b5a6978;
    logic [63:0]  b2 = 64'h55aa55aa_33cc33cc;
    int d0 = n_done;
    int t1, d1, d2;
    bit gd, ge;
    exp_q.push_back(toy(k1, b1, 1'b1));
    exp_q.push_back(toy(k2, b2, 1'b0));
    key = k1; block = b1; encdec = 1'b1; start = 1'b1;
    @(negedge clk);
    t1 = cyc;
    key = k2; block = b2; encdec = 1'b0;
    wait_end(40, gd, ge);
    d1 = cyc;
    n_cmp++; if (gd !== 1'b1 || d1 - t1 !== 11 + PD + 1) begin
      n_bad++; $display("FAIL b2b_first: got done=%b latency %0d expected 1/%0d", gd, d1 - t1, 11 + PD + 1);
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin
      n_bad++; $display("FAIL b2b_reaccept: got busy=%b expected 1", busy);
    end
    wait_end(40, gd, ge);
    d2 = cyc;
    n_cmp++; if (gd !== 1'b1 || d2 - d1 !== 12 + PD + 1) begin
      n_bad++; $display("FAIL b2b_second: got done=%b spacing %0d expected 1/%0d", gd, d2 - d1, 12 + PD + 1);
    end
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if (n_done - d0 !== 2 || busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_count: got %0d dones busy=%b expected 2/0", n_done - d0, busy);
    end
    for (int i = 0; i < 2; i++) begin
      logic [63:0] ex = exp_q.pop_front();
      n_cmp++; if (got_q.size() <= got_rd) begin
        n_bad++; $display("FAIL b2b_result%0d: got none expected %h", i, ex);
      end else begin
        if (got_q[got_rd] !== ex) begin
          n_bad++; $display("FAIL b2b_result%0d: got %h expected %h", i, got_q[got_rd], ex);
        end
        got_rd++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [127:0] k = 128'h0badcafe_0badcafe_12121212_34343434;
    logic [63:0]  b = 64'h77777777_00000001;
    int d0 = n_done;
    int e0 = n_err;
    int w0;
    bit seen = 1'b0;
    bit gd, ge;
    launch(k, b, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (cs && we && address == 8'h11) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++; if (!seen) begin
      n_bad++; $display("FAIL rstmid_reach_key: got no KEY1 write expected one");
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if ({busy, done, error, cs, we} !== 5'b0 || result !== 64'h0 ||
                 address !== 8'h0 || write_data !== 32'h0) begin
      n_bad++; $display("FAIL rstmid_outputs: got ctl=%b res=%h addr=%h wd=%h expected all 0",
                        {busy, done, error, cs, we}, result, address, write_data);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (n_done - d0 !== 0 || n_err - e0 !== 0) begin
      n_bad++; $display("FAIL rstmid_pulses: got done=%0d err=%0d expected 0/0", n_done - d0, n_err - e0);
    end
    @(negedge clk);
    w0 = wr_q.size();
    exp_q.push_back(toy(k, b, 1'b1));
    launch(k, b, 1'b1);
    wait_end(40, gd, ge);
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (wr_q.size() - w0 !== 8) begin
      n_bad++; $display("FAIL rstmid_wr_count: got %0d expected 8", wr_q.size() - w0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++; if (wr_q[w0 + i] !== exp_wr(k, b, 1'b1, i)) begin
          n_bad++; $display("FAIL rstmid_wr%0d: got %h expected %h", i, wr_q[w0 + i], exp_wr(k, b, 1'b1, i));
        end
      end
    end
    begin
      logic [63:0] ex = exp_q.pop_front();
      n_cmp++; if (got_q.size() <= got_rd) begin
        n_bad++; $display("FAIL rstmid_result: got none expected %h", ex);
      end else begin
        if (got_q[got_rd] !== ex) begin
          n_bad++; $display("FAIL rstmid_result: got %h expected %h", got_q[got_rd], ex);
        end
        got_rd++;
      end
    end
  endtask

  task automatic test_bus_addresses();
    n_cmp++; if (n_illegal !== 0) begin
      n_bad++; $display("FAIL bus_addresses: got %0d stray accesses expected 0", n_illegal);
    end
    n_cmp++; if (got_q.size() !== got_rd) begin
      n_bad++; $display("FAIL extra_done: got %0d results expected %0d", got_q.size(), got_rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_order();
    test_roundtrip();
    test_timeout();
    test_poll_latency();
    test_back_to_back();
    test_reset_mid();
    test_bus_addresses();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prince_api_master.md
Name: prince_api_master

Overview:
- Bus initiator that drives the PRINCE cipher register interface (cs/we/address/write_data/read_data) from the host side.
- It accepts one 128-bit key, one 64-bit block and a mode bit per request.
- It programs the cipher's config, key and block registers, triggers NEXT, and polls STATUS until ready.
- It then reads back the 64-bit result and reports done or error.
- It sits between a local control FSM/CPU shim and the cipher register wrapper, so software never handles the cipher registers directly.

Parameters:
- POLL_DELAY, 2: idle cycles inserted after the CTRL write before the first STATUS poll. Range 1..15.
- TIMEOUT, 255: maximum STATUS reads, in PRECHECK or in POLL, before error is raised. Range 1..65535.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only when busy=0.
- encdec  in  1  mode bit written to CONFIG bit0.
- key  in  128  cipher key; key[32i+31:32i] goes to KEY register i.
- block  in  64  input block; [31:0] goes to BLOCK0, [63:32] goes to BLOCK1.
- busy  out  1  high from the cycle after start is accepted until done/error is issued.
- done  out  1  one-cycle pulse; result is valid.
- error  out  1  one-cycle pulse; STATUS timeout.
- result  out  64  last result {RESULT1, RESULT0}; held until the next successful completion.
- cs  out  1  bus chip select.
- we  out  1  bus write enable.
- address  out  8  bus register address.
- write_data  out  32  bus write data.
- read_data  in  32  bus read data.

Behaviour:
- Reset: every output is 0 (busy, done, error, result, cs, we, address, write_data). The FSM goes to IDLE and all counters clear.
- Reset mid-operation: the FSM goes to IDLE at the reset edge. cs drops that cycle. No done or error is issued.
- Bus model: at most one transaction per cycle, all outputs registered.
  - Write: cs=1, we=1 for exactly one cycle. The responder captures it at the end of that cycle.
  - Read: cs=1, we=0. read_data is combinational from the responder, so it is sampled at the end of the same cycle.
  - When no transaction is in progress, cs=0, we=0, and address/write_data are held.
- Responder ignores writes unless it is ready. This is why PRECHECK precedes all writes.
- Start acceptance: in IDLE with start=1, latch encdec, key and block into internal registers, set busy, and go to PRECHECK. Inputs may change afterwards. start while busy=1 is ignored.
- FSM states and transitions:
  - IDLE: waits for start.
  - PRECHECK: read 0x09. If bit0=1, go to WR_CFG. Otherwise count; on reaching TIMEOUT, go to ERR.
  - WR_CFG: write 0x0a with {31'b0, encdec}.
  - WR_KEY: four cycles, writing 0x10..0x13 with key words 0..3 in order.
  - WR_BLK: two cycles, writing 0x20 = block[31:0], then 0x21 = block[63:32].
  - WR_CTRL: write 0x08 with 32'h1.
  - DELAY: POLL_DELAY cycles with cs=0.
  - POLL: read 0x09. If bit0=1, go to RD0. Otherwise count; on reaching TIMEOUT, go to ERR. The counter is cleared on entry to POLL.
  - RD0: read 0x30 and capture it into a staging register.
  - RD1: read 0x31. At the end of the cycle, result = {read_data, staging}.
  - FIN: done=1 and busy=0 in the same cycle as the done pulse, then go to IDLE.
  - ERR: error=1 and busy=0 for one cycle, then go to IDLE. result is unchanged.
- Latency, start accepted at edge T with the responder ready:
  - PRECHECK read 1, config 1, keys 4, blocks 2, CTRL 1, DELAY POLL_DELAY.
  - Then N poll reads (N ≥ 1), RD0 1, RD1 1.
  - done is high in cycle T + 12 + POLL_DELAY + N.
- A fresh start may be accepted in the cycle done/error is high, because busy=0 then. It is accepted if start=1 in that cycle.
- The timeout counter width is ceil(log2(TIMEOUT+1)) and it saturates. Exactly TIMEOUT reads occur before ERR.
- The only bus addresses ever driven are 0x08, 0x09, 0x0a, 0x10–0x13, 0x20, 0x21, 0x30 and 0x31.

Test Plan:
- Reset with real wrapper+core, then start with key=0, block=64'h0, encdec=1 → bus writes in the exact order 0x0a,0x10,0x11,0x12,0x13,0x20,0x21,0x08. done pulses once; result=64'h818665aa0d02dfda; busy is low afterwards.
- Same key, block=64'hffffffffffffffff, encdec=1 → result=64'h604ae6ca03c20ada. Then start with block=that result and encdec=0 → result=64'hffffffffffffffff.
- Stub responder with STATUS bit0 stuck 0, TIMEOUT=4 → exactly 4 reads of 0x09 and no writes. error pulses one cycle; done stays 0; result is unchanged.
- Stub with ready low for 3 polls after CTRL, POLL_DELAY=2 → exactly 4 POLL reads of 0x09 after two idle cycles. done is at T+18 relative to the start-accept edge T.
- start held high continuously → back-to-back operations. The second starts in the cycle done is high; no extra start is accepted while busy.
- reset asserted during WR_KEY → cs=0 the next cycle; all outputs are 0; no done/error. A new start afterwards completes normally.
